// File: rtl/seq_bit_feeder.sv
// Serial pattern feeder: shifts a loaded pattern out MSB first, one bit per TICK_DIV clocks,
// with pause, continuous looping and a done pulse for a downstream sequence detector.
module seq_bit_feeder #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned TICK_DIV = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] pattern,
  input  logic [3:0]       len,
  input  logic             loop_en,
  input  logic             pause,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done,
  output logic [3:0]       bit_idx
);

  localparam int unsigned TickW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);
  localparam logic [3:0] WidthL = 4'(WIDTH);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] reload_q;
  logic [3:0]       len_q;
  logic [3:0]       bit_cnt_q;
  logic [TickW-1:0] tick_q;

  logic [3:0] eff_len;
  logic       tick_end;
  logic       pat_end;

  // Zero or oversized lengths fall back to the full register width.
  always_comb begin
    eff_len = WidthL;
    if ((len != 4'd0) && (len <= WidthL)) begin
      eff_len = len;
    end
  end

  assign tick_end = (tick_q == TickLast);
  assign pat_end  = (bit_cnt_q == (len_q - 4'd1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      reload_q  <= '0;
      len_q     <= '0;
      bit_cnt_q <= '0;
      tick_q    <= '0;
      x         <= 1'b0;
      x_valid   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bit_idx   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done    <= 1'b0;
          x_valid <= 1'b0;
          x       <= 1'b0;
          busy    <= 1'b0;
          bit_idx <= '0;
          if (load) begin
            state_q   <= StShift;
            shift_q   <= pattern;
            reload_q  <= pattern;
            len_q     <= eff_len;
            bit_cnt_q <= '0;
            tick_q    <= '0;
            x         <= pattern[WIDTH-1];
            x_valid   <= 1'b1;
            busy      <= 1'b1;
          end
        end

        StShift: begin
          if (pause) begin
            // Everything holds; only the strobe is suppressed.
            x_valid <= 1'b0;
          end else if (!tick_end) begin
            tick_q  <= tick_q + 1'b1;
            x_valid <= 1'b0;
          end else if (!pat_end) begin
            tick_q    <= '0;
            bit_cnt_q <= bit_cnt_q + 4'd1;
            shift_q   <= shift_q << 1;
            x         <= shift_q[WIDTH-2];
            x_valid   <= 1'b1;
            bit_idx   <= bit_cnt_q + 4'd1;
          end else if (loop_en) begin
            tick_q    <= '0;
            bit_cnt_q <= '0;
            shift_q   <= reload_q;
            x         <= reload_q[WIDTH-1];
            x_valid   <= 1'b1;
            bit_idx   <= '0;
          end else begin
            state_q   <= StDone;
            tick_q    <= '0;
            bit_cnt_q <= '0;
            x         <= 1'b0;
            x_valid   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            bit_idx   <= '0;
          end
        end

        StDone: begin
          state_q <= StIdle;
          done    <= 1'b0;
          x       <= 1'b0;
          x_valid <= 1'b0;
          busy    <= 1'b0;
          bit_idx <= '0;
        end

        default: begin
          state_q <= StIdle;
          x       <= 1'b0;
          x_valid <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
          bit_idx <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_bit_feeder.sv
// Bench for seq_bit_feeder: two instances (TICK_DIV 1 and 3) driven by shared random stimulus
// and compared each cycle against an elapsed-time reference model.
module tb_seq_bit_feeder;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [7:0] pattern;
  logic [3:0] len;
  logic       loop_en;
  logic       pause;

  logic       x1, xv1, busy1, done1;
  logic [3:0] idx1;
  logic       x3, xv3, busy3, done3;
  logic [3:0] idx3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seq_bit_feeder #(.WIDTH(8), .TICK_DIV(1)) u_dut1 (
    .clk(clk), .reset(reset), .load(load), .pattern(pattern), .len(len),
    .loop_en(loop_en), .pause(pause),
    .x(x1), .x_valid(xv1), .busy(busy1), .done(done1), .bit_idx(idx1)
  );

  seq_bit_feeder #(.WIDTH(8), .TICK_DIV(3)) u_dut3 (
    .clk(clk), .reset(reset), .load(load), .pattern(pattern), .len(len),
    .loop_en(loop_en), .pause(pause),
    .x(x3), .x_valid(xv3), .busy(busy3), .done(done3), .bit_idx(idx3)
  );

  // Model state: st 0=idle 1=shift 2=done; el counts unpaused shift cycles since bit 0.
  typedef struct {
    int         st;
    int         el;
    int         ln;
    logic [7:0] pat;
    logic       x;
    logic       xv;
    logic       bz;
    logic       dn;
    int         idx;
  } mdl_t;

  mdl_t m1 = '{default: 0};
  mdl_t m3 = '{default: 0};

  function automatic mdl_t mdl_step(mdl_t s, int d, logic rst, logic ld, logic [7:0] p,
                                    logic [3:0] l, logic lp, logic ps);
    mdl_t n;
    int   k;
    n = s;
    if (rst) begin
      n = '{default: 0};
      return n;
    end
    n.dn = 1'b0;
    case (s.st)
      0: begin
        n.xv = 1'b0;
        if (ld) begin
          n.pat = p;
          n.ln  = (l >= 1 && l <= 8) ? int'(l) : 8;
          n.el  = 0;
          n.st  = 1;
          n.bz  = 1'b1;
          n.x   = p[7];
          n.xv  = 1'b1;
          n.idx = 0;
        end
      end
      1: begin
        if (ps) begin
          n.xv = 1'b0;
        end else begin
          n.el = s.el + 1;
          if (n.el == s.ln * d) begin
            if (lp) begin
              n.el  = 0;
              n.x   = s.pat[7];
              n.xv  = 1'b1;
              n.idx = 0;
            end else begin
              n.st  = 2;
              n.dn  = 1'b1;
              n.x   = 1'b0;
              n.xv  = 1'b0;
              n.bz  = 1'b0;
              n.idx = 0;
            end
          end else begin
            k     = n.el / d;
            n.x   = s.pat[7-k];
            n.idx = k;
            n.xv  = ((n.el % d) == 0);
          end
        end
      end
      default: n.st = 0;
    endcase
    return n;
  endfunction

  always @(posedge clk) begin
    m1 = mdl_step(m1, 1, reset, load, pattern, len, loop_en, pause);
    m3 = mdl_step(m3, 3, reset, load, pattern, len, loop_en, pause);
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input int cyc);
    check_val($sformatf("x1@%0d", cyc), int'(x1), int'(m1.x));
    check_val($sformatf("xv1@%0d", cyc), int'(xv1), int'(m1.xv));
    check_val($sformatf("busy1@%0d", cyc), int'(busy1), int'(m1.bz));
    check_val($sformatf("done1@%0d", cyc), int'(done1), int'(m1.dn));
    check_val($sformatf("idx1@%0d", cyc), int'(idx1), m1.idx);
    check_val($sformatf("x3@%0d", cyc), int'(x3), int'(m3.x));
    check_val($sformatf("xv3@%0d", cyc), int'(xv3), int'(m3.xv));
    check_val($sformatf("busy3@%0d", cyc), int'(busy3), int'(m3.bz));
    check_val($sformatf("done3@%0d", cyc), int'(done3), int'(m3.dn));
    check_val($sformatf("idx3@%0d", cyc), int'(idx3), m3.idx);
  endtask

  initial begin
    logic [3:0] seen;
    int         nseen;

    reset   = 1'b1;
    load    = 1'b0;
    pattern = '0;
    len     = '0;
    loop_en = 1'b0;
    pause   = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check_val("rst_x", int'(x1), 0);
    check_val("rst_busy", int'(busy3), 0);
    check_val("rst_idx", int'(idx1), 0);

    // Directed: 1101 then done at T0+4 on the TICK_DIV=1 instance, as a detector would see it
    reset   = 1'b0;
    load    = 1'b1;
    pattern = 8'b1101_0000;
    len     = 4'd4;
    seen    = '0;
    nseen   = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      load = 1'b0;
      check_all(c);
      if (xv1) begin
        seen = {seen[2:0], x1};
        nseen++;
      end
    end
    check_val("det_count", nseen, 4);
    check_val("det_1101", int'(seen), 13);
    @(negedge clk);
    check_val("done_t0p4", int'(done1), 1);
    check_all(4);

    // Randomized phase
    for (int c = 5; c < 2500; c++) begin
      reset   = ($urandom_range(0, 99) < 2);
      load    = ($urandom_range(0, 3) == 0);
      pattern = 8'($urandom);
      len     = 4'($urandom_range(0, 15));
      loop_en = ($urandom_range(0, 3) == 0);
      pause   = ($urandom_range(0, 5) == 0);
      @(negedge clk);
      check_all(c);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
